controle_senha_param: RTL and testbench

Parametrised control unit for the DigiLock keypad lock. It owns password storage, digit sequencing, comparison, a failed-attempt counter with lockout, and a timed unlock output. It replaces the fixed 4-digit control unit plus its external memory and verifier. It sits between the keypad decoder (digit plus key-strobe) and the lock actuator and status LEDs.

---
 rtl/controle_senha_pkg.sv | 25 ++
 rtl/controle_senha_param_temporizador.sv | 28 ++
 rtl/controle_senha_param.sv | 244 ++++++++++++++++++++++++
 tb/tb_controle_senha_param.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/controle_senha_pkg.sv
// Shared state encoding and default parameter values for the DigiLock control unit.
package controle_senha_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    CONFIG,
    VERIFICA,
    ABERTO,
    BLOQUEIO
  } estado_t;

  localparam int NUM_DIGITOS_PADRAO     = 4;
  localparam int LARG_DIGITO_PADRAO     = 4;
  localparam int MAX_TENTATIVAS_PADRAO  = 3;
  localparam int CICLOS_ABERTO_PADRAO   = 8;
  localparam int CICLOS_BLOQUEIO_PADRAO = 16;
  localparam int CICLOS_TIMEOUT_PADRAO  = 32;

  function automatic int maximo3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/controle_senha_param_temporizador.sv
// Loadable down-counter that stops at zero; shared by the open, lockout and
// digit-timeout phases of the lock controller.
module temporizador_param #(
  parameter int LARGURA = 5
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [LARGURA-1:0] valor,
  input  logic               en,
  output logic               zero
);

  logic [LARGURA-1:0] cont;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cont <= '0;
    end else if (load) begin
      cont <= valor;
    end else if (en && (cont != '0)) begin
      cont <= cont - 1'b1;
    end
  end

  assign zero = (cont == '0);

endmodule

// File: rtl/controle_senha_param.sv
// DigiLock control unit: password storage, digit sequencing, attempt counting,
// lockout and timed unlock. Optional per-digit idle timeout: TIMEOUT_DIGITO_EN.
//
// state    | meaning
// OCIOSO   | idle, waiting for the first digit of a sequence
// CONFIG   | collecting a new password into the shadow buffer
// VERIFICA | comparing entered digits against the stored password
// ABERTO   | lock open for CICLOS_ABERTO cycles
// BLOQUEIO | lockout for CICLOS_BLOQUEIO cycles, keys ignored
module controle_senha_param
  import controle_senha_pkg::*;
#(
  parameter int NUM_DIGITOS     = NUM_DIGITOS_PADRAO,
  parameter int LARG_DIGITO     = LARG_DIGITO_PADRAO,
  parameter int MAX_TENTATIVAS  = MAX_TENTATIVAS_PADRAO,
  parameter int CICLOS_ABERTO   = CICLOS_ABERTO_PADRAO,
  parameter int CICLOS_BLOQUEIO = CICLOS_BLOQUEIO_PADRAO,
  parameter int CICLOS_TIMEOUT  = CICLOS_TIMEOUT_PADRAO
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           modo,
  input  logic                           tecla_ativada,
  input  logic [LARG_DIGITO-1:0]         tecla,
  output logic                           aberto,
  output logic                           erro,
  output logic                           bloqueado,
  output logic                           senha_gravada,
  output logic                           configurando,
  output logic [$clog2(NUM_DIGITOS)-1:0] indice
);

  localparam int IW   = $clog2(NUM_DIGITOS);
  localparam int FW   = $clog2(MAX_TENTATIVAS + 1);
  localparam int TMAX = maximo3(CICLOS_ABERTO, CICLOS_BLOQUEIO, CICLOS_TIMEOUT);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [IW-1:0] ULTIMO      = IW'(NUM_DIGITOS - 1);
  localparam logic [FW-1:0] FALHA_LIMITE = FW'(MAX_TENTATIVAS - 1);
  localparam logic [TW-1:0] T_ABERTO    = TW'(CICLOS_ABERTO - 1);
  localparam logic [TW-1:0] T_BLOQUEIO  = TW'(CICLOS_BLOQUEIO - 1);
  localparam logic [TW-1:0] T_TIMEOUT   = TW'(CICLOS_TIMEOUT - 1);

`ifdef TIMEOUT_DIGITO_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  estado_t                estado;
  logic                   prev;
  logic [LARG_DIGITO-1:0] senha [NUM_DIGITOS];
  logic [LARG_DIGITO-1:0] novo  [NUM_DIGITOS];
  logic                   senha_valida;
  logic                   dif;
  logic [FW-1:0]          falhas;

  logic          aceita;
  logic          ultimo;
  logic          dif_final;
  logic          acerto;
  logic          esgotou;
  logic          expira;
  logic          tempo_zero;
  logic          carga;
  logic [TW-1:0] valor_carga;
  logic          en_tempo;

  assign aceita    = tecla_ativada & ~prev;
  assign ultimo    = (indice == ULTIMO);
  assign dif_final = dif | (tecla != senha[indice]);
  // Without a committed password every verification is a mismatch.
  assign acerto    = ~dif_final & senha_valida;
  assign esgotou   = (falhas == FALHA_LIMITE);
  assign expira    = TMO_EN && ((estado == CONFIG) || (estado == VERIFICA)) && tempo_zero;
  assign en_tempo  = (estado != OCIOSO);

  always_comb begin
    carga       = 1'b0;
    valor_carga = '0;
    case (estado)
      OCIOSO: begin
        if (aceita && !(modo && senha_valida)) begin
          carga       = TMO_EN;
          valor_carga = T_TIMEOUT;
        end
      end
      CONFIG: begin
        if (aceita && !expira && !ultimo) begin
          carga       = TMO_EN;
          valor_carga = T_TIMEOUT;
        end
      end
      VERIFICA: begin
        if (aceita && !expira) begin
          if (ultimo) begin
            carga       = 1'b1;
            valor_carga = acerto ? T_ABERTO : T_BLOQUEIO;
          end else begin
            carga       = TMO_EN;
            valor_carga = T_TIMEOUT;
          end
        end
      end
      ABERTO: begin
        if (aceita && modo && !tempo_zero) begin
          carga       = TMO_EN;
          valor_carga = T_TIMEOUT;
        end
      end
      default: ;
    endcase
  end

  temporizador_param #(
    .LARGURA(TW)
  ) u_tempo (
    .clk   (clk),
    .reset (reset),
    .load  (carga),
    .valor (valor_carga),
    .en    (en_tempo),
    .zero  (tempo_zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado        <= OCIOSO;
      prev          <= 1'b0;
      senha         <= '{default: '0};
      novo          <= '{default: '0};
      senha_valida  <= 1'b0;
      dif           <= 1'b0;
      falhas        <= '0;
      indice        <= '0;
      aberto        <= 1'b0;
      erro          <= 1'b0;
      bloqueado     <= 1'b0;
      senha_gravada <= 1'b0;
      configurando  <= 1'b0;
    end else begin
      prev          <= tecla_ativada;
      erro          <= 1'b0;
      senha_gravada <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (aceita) begin
            if (modo) begin
              if (!senha_valida) begin
                estado       <= CONFIG;
                configurando <= 1'b1;
                novo[0]      <= tecla;
                indice       <= IW'(1);
              end else begin
                erro <= 1'b1;
              end
            end else begin
              estado <= VERIFICA;
              dif    <= (tecla != senha[0]);
              indice <= IW'(1);
            end
          end
        end

        CONFIG: begin
          if (expira) begin
            estado       <= OCIOSO;
            configurando <= 1'b0;
            indice       <= '0;
            erro         <= 1'b1;
          end else if (aceita) begin
            novo[indice] <= tecla;
            if (ultimo) begin
              // The final digit bypasses the shadow buffer so the commit lands on this edge.
              for (int i = 0; i < NUM_DIGITOS - 1; i++) senha[i] <= novo[i];
              senha[NUM_DIGITOS-1] <= tecla;
              senha_valida  <= 1'b1;
              falhas        <= '0;
              senha_gravada <= 1'b1;
              estado        <= OCIOSO;
              configurando  <= 1'b0;
              indice        <= '0;
            end else begin
              indice <= indice + 1'b1;
            end
          end
        end

        VERIFICA: begin
          if (expira) begin
            estado <= OCIOSO;
            indice <= '0;
            erro   <= 1'b1;
          end else if (aceita) begin
            dif <= dif_final;
            if (ultimo) begin
              indice <= '0;
              if (acerto) begin
                estado <= ABERTO;
                aberto <= 1'b1;
                falhas <= '0;
              end else if (esgotou) begin
                estado    <= BLOQUEIO;
                bloqueado <= 1'b1;
                falhas    <= '0;
              end else begin
                estado <= OCIOSO;
                falhas <= falhas + 1'b1;
                erro   <= 1'b1;
              end
            end else begin
              indice <= indice + 1'b1;
            end
          end
        end

        ABERTO: begin
          if (tempo_zero) begin
            estado <= OCIOSO;
            aberto <= 1'b0;
          end else if (aceita && modo) begin
            estado       <= CONFIG;
            aberto       <= 1'b0;
            configurando <= 1'b1;
            novo[0]      <= tecla;
            indice       <= IW'(1);
          end
        end

        BLOQUEIO: begin
          if (tempo_zero) begin
            estado    <= OCIOSO;
            bloqueado <= 1'b0;
          end
        end

        default: begin
          estado <= OCIOSO;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_controle_senha_param.sv
// Cycle-accurate scoreboard bench for controle_senha_param at default parameters.
module tb_controle_senha_param;

  logic       clk;
  logic       reset;
  logic       modo;
  logic       tecla_ativada;
  logic [3:0] tecla;
  logic       aberto, erro, bloqueado, senha_gravada, configurando;
  logic [1:0] indice;

  int passou = 0;
  int total  = 0;
  logic [6:0] fila [$];

  controle_senha_param dut (
    .clk           (clk),
    .reset         (reset),
    .modo          (modo),
    .tecla_ativada (tecla_ativada),
    .tecla         (tecla),
    .aberto        (aberto),
    .erro          (erro),
    .bloqueado     (bloqueado),
    .senha_gravada (senha_gravada),
    .configurando  (configurando),
    .indice        (indice)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] saida;
  assign saida = {aberto, erro, bloqueado, senha_gravada, configurando, indice};

  function automatic logic [6:0] v(input logic ab, input logic er, input logic bl,
                                   input logic sg, input logic cf, input int ind);
    logic [1:0] i2;
    i2 = ind[1:0];
    return {ab, er, bl, sg, cf, i2};
  endfunction

  task automatic confere(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    total++;
    if (obs === esp) passou++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, esp);
  endtask

  // Drive one cycle of stimulus, queue the expected outputs, compare on the falling edge.
  task automatic passo(input logic ativ, input logic [3:0] d, input logic m,
                       input logic [6:0] esp, input string tag);
    logic [6:0] e;
    tecla_ativada = ativ;
    tecla         = d;
    modo          = m;
    fila.push_back(esp);
    @(posedge clk);
    @(negedge clk);
    e = fila.pop_front();
    confere(tag, {25'd0, saida}, {25'd0, e});
  endtask

  task automatic digito(input logic [3:0] d, input logic m, input logic [6:0] esp_press,
                        input logic [6:0] esp_solta, input string tag);
    passo(1'b1, d, m, esp_press, tag);
    passo(1'b0, d, m, esp_solta, tag);
  endtask

  task automatic espera(input int n, input logic [6:0] esp, input string tag);
    for (int i = 0; i < n; i++) passo(1'b0, 4'd0, 1'b0, esp, tag);
  endtask

  // Four-digit sequence; intermediate digits show configurando = m and indice 1..3.
  task automatic senha4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                        input logic [3:0] d, input logic m, input logic [6:0] fim,
                        input logic [6:0] fim_solta, input string tag);
    digito(a, m, v(0,0,0,0,m,1), v(0,0,0,0,m,1), tag);
    digito(b, m, v(0,0,0,0,m,2), v(0,0,0,0,m,2), tag);
    digito(c, m, v(0,0,0,0,m,3), v(0,0,0,0,m,3), tag);
    digito(d, m, fim, fim_solta, tag);
  endtask

  initial begin
    logic [6:0] zero_v, abre_v, erro_v, grav_v, bloq_v;
    zero_v = v(0,0,0,0,0,0);
    abre_v = v(1,0,0,0,0,0);
    erro_v = v(0,1,0,0,0,0);
    grav_v = v(0,0,0,1,0,0);
    bloq_v = v(0,0,1,0,0,0);

    reset = 1'b1; modo = 1'b0; tecla_ativada = 1'b0; tecla = 4'd0;
    repeat (2) @(negedge clk);
    confere("reset", {25'd0, saida}, 32'd0);
    reset = 1'b0;

    // 1: configure 1-2-3-4
    senha4(4'd1, 4'd2, 4'd3, 4'd4, 1'b1, grav_v, zero_v, "config");

    // 2: open with 1-2-3-4, exactly 8 cycles
    senha4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, abre_v, abre_v, "abre");
    espera(6, abre_v, "abre_hold");
    espera(1, zero_v, "abre_fim");

    // 3: three wrong attempts -> lockout 16 cycles, keys ignored
    senha4(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, erro_v, zero_v, "erro1");
    senha4(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, erro_v, zero_v, "erro2");
    senha4(4'd1, 4'd2, 4'd3, 4'd5, 1'b0, bloq_v, bloq_v, "bloqueio");
    digito(4'd1, 1'b0, bloq_v, bloq_v, "bloq_tecla");
    digito(4'd2, 1'b1, bloq_v, bloq_v, "bloq_tecla");
    digito(4'd3, 1'b0, bloq_v, bloq_v, "bloq_tecla");
    espera(8, bloq_v, "bloq_hold");
    espera(1, zero_v, "bloq_fim");
    senha4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, abre_v, abre_v, "abre_pos_bloq");
    espera(6, abre_v, "abre_hold");
    espera(1, zero_v, "abre_fim");

    // 4: modo=1 with password set is rejected; reconfigure during ABERTO
    digito(4'd7, 1'b1, erro_v, zero_v, "config_rejeitada");
    senha4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, abre_v, abre_v, "abre");
    senha4(4'd9, 4'd8, 4'd7, 4'd6, 1'b1, grav_v, zero_v, "config_aberto");
    senha4(4'd1, 4'd2, 4'd3, 4'd4, 1'b0, erro_v, zero_v, "antiga_falha");
    senha4(4'd9, 4'd8, 4'd7, 4'd6, 1'b0, abre_v, abre_v, "nova_abre");
    espera(6, abre_v, "abre_hold");
    espera(1, zero_v, "abre_fim");

    // 5: held key counts once; async reset mid-verification
    for (int i = 0; i < 10; i++) passo(1'b1, 4'd9, 1'b0, v(0,0,0,0,0,1), "tecla_segura");
    passo(1'b0, 4'd9, 1'b0, v(0,0,0,0,0,1), "tecla_solta");
    digito(4'd8, 1'b0, v(0,0,0,0,0,2), v(0,0,0,0,0,2), "segundo_digito");
    #2 reset = 1'b1;
    #1 confere("reset_assinc", {25'd0, saida}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    senha4(4'd0, 4'd0, 4'd0, 4'd0, 1'b0, erro_v, zero_v, "sem_senha");
    senha4(4'd1, 4'd1, 4'd1, 4'd1, 1'b1, grav_v, zero_v, "config_pos_reset");

`ifdef TIMEOUT_DIGITO_EN
    // 6: idle timeout in VERIFICA pulses erro without counting a failure
    digito(4'd5, 1'b0, v(0,0,0,0,0,1), v(0,0,0,0,0,1), "tmo_d1");
    digito(4'd5, 1'b0, v(0,0,0,0,0,2), v(0,0,0,0,0,2), "tmo_d2");
    espera(30, v(0,0,0,0,0,2), "tmo_espera");
    espera(1, erro_v, "tmo_erro");
    espera(1, zero_v, "tmo_fim");
    senha4(4'd2, 4'd2, 4'd2, 4'd2, 1'b0, erro_v, zero_v, "tmo_falha1");
    senha4(4'd2, 4'd2, 4'd2, 4'd2, 1'b0, erro_v, zero_v, "tmo_falha2");
`endif

    $display("%0d/%0d checks passed", passou, total);
    $finish;
  end

endmodule
